// File: rtl/div_seq_param_if.sv
// Divider request/result bundle shared between the execution-stage control and the divider.
interface div_seq_param_if #(
  parameter int unsigned WIDTH = 32
);
  logic             DIV_START;
  logic             DIV_ABORT;
  logic             SIGNED;
  logic [WIDTH-1:0] DIVIDEND;
  logic [WIDTH-1:0] DIVISOR;
  logic [WIDTH-1:0] QUOTIENT;
  logic [WIDTH-1:0] REMAINDER;
  logic             ready;
  logic             div_busy;
  logic             divide_zero;

  modport master (
    output DIV_START, DIV_ABORT, SIGNED, DIVIDEND, DIVISOR,
    input  QUOTIENT, REMAINDER, ready, div_busy, divide_zero
  );

  modport slave (
    input  DIV_START, DIV_ABORT, SIGNED, DIVIDEND, DIVISOR,
    output QUOTIENT, REMAINDER, ready, div_busy, divide_zero
  );
endinterface

// File: rtl/div_seq_param.sv
// Multi-cycle restoring divider (DIV/DIVU) with zero-divisor and signed-overflow fast paths
// and an abort that kills an in-flight operation without disturbing the held results.
module div_seq_param #(
  parameter int unsigned WIDTH = 32
) (
  input logic            CLK,
  input logic            RST,
  div_seq_param_if.slave div_if
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;
  logic             r_ovf;
  logic             r_ready;
  logic             r_busy;
  logic             r_dz;

  logic             w_start;
  logic             w_finish;
  logic             w_kill;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_qbit;
  logic [WIDTH-1:0] w_min_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;

  // Operand classification and magnitudes; min-negative maps onto its own unsigned magnitude.
  assign w_min_neg  = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_div_zero = (div_if.DIVISOR == '0);
  assign w_ovf      = div_if.SIGNED && (div_if.DIVIDEND == w_min_neg) && (div_if.DIVISOR == '1);
  assign w_abs_a    = (div_if.SIGNED && div_if.DIVIDEND[WIDTH-1]) ? -div_if.DIVIDEND : div_if.DIVIDEND;
  assign w_abs_b    = (div_if.SIGNED && div_if.DIVISOR[WIDTH-1])  ? -div_if.DIVISOR  : div_if.DIVISOR;

  // One restoring step: the stored remainder is always below the divisor, so WIDTH bits hold it
  // and only the shifted partial remainder needs the extra bit.
  assign w_shift   = {r_p, r_dvd[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_dsr};
  assign w_qbit    = ~w_trial[WIDTH];
  assign w_rem_nxt = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    w_kill      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (div_if.DIV_START && !div_if.DIV_ABORT) begin
          w_start     = 1'b1;
          w_state_nxt = (w_div_zero || w_ovf) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (div_if.DIV_ABORT) begin
          w_kill      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        if (div_if.DIV_ABORT) begin
          w_kill      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and result registers; results change only on a completed FIX.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_ready <= w_finish;
      if (w_start) begin
        r_cnt   <= '0;
        r_p     <= '0;
        r_neg_q <= div_if.SIGNED && (div_if.DIVIDEND[WIDTH-1] ^ div_if.DIVISOR[WIDTH-1]);
        r_neg_r <= div_if.SIGNED && div_if.DIVIDEND[WIDTH-1];
        r_dvd   <= w_div_zero ? div_if.DIVIDEND : w_abs_a;
        r_dsr   <= w_abs_b;
        r_zero  <= w_div_zero;
        r_ovf   <= !w_div_zero && w_ovf;
        r_busy  <= 1'b1;
      end else if (r_state == S_CALC) begin
        r_p   <= w_rem_nxt;
        r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_kill) r_busy <= 1'b0;
      if (w_finish) begin
        r_busy <= 1'b0;
        if (r_zero) begin
          r_q  <= '1;
          r_r  <= r_dvd;
          r_dz <= 1'b1;
        end else if (r_ovf) begin
          r_q  <= w_min_neg;
          r_r  <= '0;
          r_dz <= 1'b0;
        end else begin
          r_q  <= r_neg_q ? -r_dvd : r_dvd;
          r_r  <= r_neg_r ? -r_p : r_p;
          r_dz <= 1'b0;
        end
      end
    end
  end

  assign div_if.QUOTIENT    = r_q;
  assign div_if.REMAINDER   = r_r;
  assign div_if.ready       = r_ready;
  assign div_if.div_busy    = r_busy;
  assign div_if.divide_zero = r_dz;

endmodule

// File: tb/tb_div_seq_param.sv
// Directed bench for div_seq_param: 32-bit and 8-bit instances, vector table plus
// hand-written sequences for ignored start, abort, async reset and back-to-back issue.
module tb_div_seq_param;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_seq_param_if #(.WIDTH(32)) if32();
  div_seq_param_if #(.WIDTH(8))  if8();

  div_seq_param #(.WIDTH(32)) dut32 (.CLK(clk), .RST(rst_n), .div_if(if32.slave));
  div_seq_param #(.WIDTH(8))  dut8  (.CLK(clk), .RST(rst_n), .div_if(if8.slave));

  typedef struct {
    logic        sel8;
    logic        b2b;
    logic        sgn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sel8, input logic start, input logic abort, input logic sgn,
                       input logic [63:0] a, input logic [63:0] b);
    if (sel8) begin
      if8.DIV_START = start; if8.DIV_ABORT = abort; if8.SIGNED = sgn;
      if8.DIVIDEND  = a[7:0]; if8.DIVISOR  = b[7:0];
    end else begin
      if32.DIV_START = start; if32.DIV_ABORT = abort; if32.SIGNED = sgn;
      if32.DIVIDEND  = a[31:0]; if32.DIVISOR  = b[31:0];
    end
  endtask

  function automatic logic [63:0] q_of(input logic sel8);
    return sel8 ? {56'd0, if8.QUOTIENT} : {32'd0, if32.QUOTIENT};
  endfunction
  function automatic logic [63:0] r_of(input logic sel8);
    return sel8 ? {56'd0, if8.REMAINDER} : {32'd0, if32.REMAINDER};
  endfunction
  function automatic logic rdy_of(input logic sel8);
    return sel8 ? if8.ready : if32.ready;
  endfunction
  function automatic logic busy_of(input logic sel8);
    return sel8 ? if8.div_busy : if32.div_busy;
  endfunction
  function automatic logic dz_of(input logic sel8);
    return sel8 ? if8.divide_zero : if32.divide_zero;
  endfunction

  // Issue one op, count edges to ready and busy-high samples, then compare the results.
  task automatic run_op(input string tag, input vec_t v);
    int n;
    int busy_n;
    if (!v.b2b) @(negedge clk);
    drive(v.sel8, 1'b1, 1'b0, v.sgn, v.a, v.b);
    @(negedge clk);
    drive(v.sel8, 1'b0, 1'b0, v.sgn, v.a, v.b);
    n = 0;
    busy_n = 0;
    while (!rdy_of(v.sel8) && n < 200) begin
      if (busy_of(v.sel8)) busy_n++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"},   64'(rdy_of(v.sel8)), 64'd1);
    chk({tag, "_latency"}, 64'(n), 64'(v.lat));
    chk({tag, "_busycyc"}, 64'(busy_n), 64'(v.lat));
    chk({tag, "_busyoff"}, 64'(busy_of(v.sel8)), 64'd0);
    chk({tag, "_q"},       q_of(v.sel8), v.q);
    chk({tag, "_r"},       r_of(v.sel8), v.r);
    chk({tag, "_dz"},      64'(dz_of(v.sel8)), 64'(v.dz));
  endtask

  task automatic count_ready(input logic sel8, input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (rdy_of(sel8)) cnt++;
    end
  endtask

  initial begin
    int n;
    int cnt;
    vec_t v;

    // sel8, b2b, sgn, a, b, q, r, dz, lat
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 64'd100,        64'd7,          64'd14,         64'd2,          1'b0, 33};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 64'hFFFFFF9C,   64'd7,          64'hFFFFFFF2,   64'hFFFFFFFE,   1'b0, 33};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 64'd100,        64'hFFFFFFF9,   64'hFFFFFFF2,   64'd2,          1'b0, 33};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 64'hFFFFFFFF,   64'd2,          64'h7FFFFFFF,   64'd1,          1'b0, 33};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 64'h80000000,   64'hFFFFFFFF,   64'h80000000,   64'd0,          1'b0, 1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 64'd5,          64'd0,          64'hFFFFFFFF,   64'd5,          1'b1, 1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 64'hFFFFFFFB,   64'd0,          64'hFFFFFFFF,   64'hFFFFFFFB,   1'b1, 1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 64'h80000000,   64'hFFFFFFFF,   64'd0,          64'h80000000,   1'b0, 33};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 64'hFFFFFFF9,   64'd2,          64'hFFFFFFFD,   64'hFFFFFFFF,   1'b0, 33};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 64'h80000000,   64'd1,          64'h80000000,   64'd0,          1'b0, 33};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 64'd255,        64'd16,         64'd15,         64'd15,         1'b0, 9};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 64'h80,         64'hFF,         64'h80,         64'd0,          1'b0, 1};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 64'h85,         64'd0,          64'hFF,         64'h85,         1'b1, 1};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 64'd200,        64'd7,          64'd28,         64'd4,          1'b0, 9};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 64'd100,        64'd9,          64'd11,         64'd1,          1'b0, 9};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 64'h80,         64'hFF,         64'h80,         64'd0,          1'b0, 1};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 64'h90,         64'd5,          64'hEA,         64'hFE,         1'b0, 9};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);

    repeat (2) @(negedge clk);
    chk("rst_q",     q_of(1'b0), 64'd0);
    chk("rst_r",     r_of(1'b0), 64'd0);
    chk("rst_ready", 64'(rdy_of(1'b0)), 64'd0);
    chk("rst_busy",  64'(busy_of(1'b0)), 64'd0);
    chk("rst_dz",    64'(dz_of(1'b0)), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_op($sformatf("v%0d", i), vecs[i]);

    // Start during CALC is ignored.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 64'd1000, 64'd3);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd1000, 64'd3);
    n = 0;
    while (!if32.ready && n < 200) begin
      if (n == 9)  drive(1'b0, 1'b1, 1'b0, 1'b0, 64'd9, 64'd9);
      if (n == 10) drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd9, 64'd9);
      @(negedge clk);
      n++;
    end
    chk("ign_latency", 64'(n), 64'd33);
    chk("ign_q", q_of(1'b0), 64'd333);
    chk("ign_r", r_of(1'b0), 64'd1);
    count_ready(1'b0, 40, cnt);
    chk("ign_noextra", 64'(cnt), 64'd0);

    // Abort during CALC at edge k+5.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 64'd12, 64'd5);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd12, 64'd5);
    repeat (4) @(negedge clk);
    chk("abt_busy_pre", 64'(if32.div_busy), 64'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'd12, 64'd5);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd12, 64'd5);
    chk("abt_busy", 64'(if32.div_busy), 64'd0);
    count_ready(1'b0, 40, cnt);
    chk("abt_noready", 64'(cnt), 64'd0);
    chk("abt_q", q_of(1'b0), 64'd333);
    chk("abt_r", r_of(1'b0), 64'd1);

    // Abort in FIX on the divide-by-zero fast path.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 64'd5, 64'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'd5, 64'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd5, 64'd0);
    chk("abtfix_busy", 64'(if32.div_busy), 64'd0);
    count_ready(1'b0, 5, cnt);
    chk("abtfix_noready", 64'(cnt), 64'd0);
    chk("abtfix_q",  q_of(1'b0), 64'd333);
    chk("abtfix_dz", 64'(dz_of(1'b0)), 64'd0);

    // Start and abort together in IDLE: start suppressed.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'd9, 64'd9);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd9, 64'd9);
    chk("sa_busy", 64'(if32.div_busy), 64'd0);
    count_ready(1'b0, 40, cnt);
    chk("sa_noready", 64'(cnt), 64'd0);
    chk("sa_q", q_of(1'b0), 64'd333);

    // Asynchronous reset in the middle of CALC.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 64'd77, 64'd3);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd77, 64'd3);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q",    q_of(1'b0), 64'd0);
    chk("arst_r",    r_of(1'b0), 64'd0);
    chk("arst_busy", 64'(if32.div_busy), 64'd0);
    chk("arst_q8",   q_of(1'b1), 64'd0);
    chk("arst_r8",   r_of(1'b1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_ready(1'b0, 40, cnt);
    chk("arst_noready", 64'(cnt), 64'd0);
    v = '{1'b0, 1'b0, 1'b0, 64'd50, 64'd5, 64'd10, 64'd0, 1'b0, 33};
    run_op("post_rst", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq_param.md
Name: div_seq_param

Overview:
Parametrised multi-cycle restoring divider for the MIPS execution stage, producing DIV/DIVU results for the HI/LO writeback path.
- Generalised in operand width.
- Proper WIDTH-bit remainder.
- Registered, held results.
- Dedicated divide-by-zero and signed-overflow fast paths.
- Abort input so an exception can kill an in-flight divide.
Sits beside the multiplier; the control FSM stalls on div_busy and captures results on ready.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits (legal 4..64).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous active-low reset
DIV_START  input  1  start request; sampled only in IDLE or DONE
DIV_ABORT  input  1  kill in-flight operation; priority over DIV_START
SIGNED  input  1  1 = two's-complement DIV, 0 = DIVU; sampled with DIV_START
DIVIDEND  input  WIDTH  numerator; sampled with DIV_START
DIVISOR  input  WIDTH  denominator; sampled with DIV_START
QUOTIENT  output  WIDTH  registered quotient (LO)
REMAINDER  output  WIDTH  registered remainder (HI)
ready  output  1  one-cycle pulse: results valid and updated this cycle
div_busy  output  1  high while an operation is in flight
divide_zero  output  1  registered flag: last completed op had DIVISOR==0; held with results

Behaviour:
- Reset (RST low, async):
  - State is IDLE.
  - QUOTIENT=0, REMAINDER=0, ready=0, div_busy=0, divide_zero=0.
  - Counter=0 and internal registers cleared.
  - Reset mid-operation discards the operation; no ready pulse follows.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE, DIV_START=1 (DIV_ABORT=0):
  - Latch SIGNED, the sign bits, |DIVIDEND| and |DIVISOR|.
  - Set div_busy=1.
  - If DIVISOR==0, go to FIX with the zero flag set.
  - Else, if SIGNED and DIVIDEND==min-negative and DIVISOR==all-ones, go to FIX with the overflow flag set.
  - Else load counter=0 and go to CALC.
- CALC, one quotient bit per cycle:
  - Partial remainder P (WIDTH+1 bits) shifts left by one, taking the next dividend MSB.
  - Trial T=P-|divisor|. If T>=0 then P=T and q bit=1, else q bit=0.
  - After WIDTH iterations (counter==WIDTH-1 on the final edge) go to FIX.
- FIX, single cycle; writes the output registers:
  - Normal: QUOTIENT negated if the latched sign bits differ (signed only); REMAINDER negated if the dividend was negative (signed only). Remainder sign follows the dividend.
  - Zero: QUOTIENT=all-ones, REMAINDER=DIVIDEND as sampled (unmodified), divide_zero=1.
  - Overflow: QUOTIENT=min-negative, REMAINDER=0, divide_zero=0.
  - divide_zero=0 on every non-zero-divisor result.
  - Transition to DONE: ready=1 for exactly that cycle, div_busy=0.
- DONE:
  - Outputs are held and ready returns to 0 after one cycle.
  - Remains in DONE (functionally same as IDLE) until the next DIV_START.
- Latency, with DIV_START sampled at edge k:
  - Normal: ready high after edge k+WIDTH+1. For WIDTH=32, that is 33 edges.
  - Zero/overflow fast path: ready high after edge k+1.
- DIV_START while in CALC or FIX: ignored, with no effect on the operation or the latched operands.
- DIV_ABORT:
  - In CALC or FIX, return to IDLE at the next edge with div_busy=0 and no ready pulse.
  - Outputs keep their previous values.
  - If DIV_ABORT and DIV_START are both high in IDLE/DONE, the start is suppressed.
- Back-to-back: DIV_START in the DONE cycle (same cycle ready=1) starts a new op. Outputs stay valid until the new FIX.
- Width rules:
  - |min-negative| is held as an unsigned WIDTH-bit magnitude (no overflow in CALC).
  - All arithmetic is WIDTH+1 bits internally.
  - Unsigned operands are never negated.

Test Plan:
- WIDTH=32, SIGNED=0, 100/7 -> QUOTIENT=14, REMAINDER=2, ready exactly 33 edges after start, div_busy high for those 33 cycles.
- WIDTH=32, SIGNED=1, -100/7 -> Q=0xFFFFFFF2 (-14), R=0xFFFFFFFE (-2). Then 100/-7 -> Q=-14, R=2. Then DIVU 0xFFFFFFFF/2 -> Q=0x7FFFFFFF, R=1.
- SIGNED=1, 0x80000000/0xFFFFFFFF -> Q=0x80000000, R=0, divide_zero=0, ready 1 edge after start. Then 5/0 -> Q=0xFFFFFFFF, R=5, divide_zero=1, ready 1 edge after start.
- Start 1000/3. Pulse DIV_START with 9/9 at edge k+10 -> ignored; result Q=333, R=1. Then DIV_ABORT at edge k+5 of a new op -> div_busy=0 next cycle, no ready, outputs still 333/1.
- Assert RST low mid-CALC -> all outputs 0 immediately (async). After release, start 50/5 -> Q=10, R=0 with normal latency.
- WIDTH=8 instance: SIGNED=0, 255/16 -> Q=15, R=15, ready after 9 edges. SIGNED=1, -128/-1 -> Q=0x80, R=0. Back-to-back start in the DONE cycle -> both results correct.
